// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encoding, the default HALT opcode and the opcode-extraction helper.
package fetch_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    localparam int               DEFAULT_OPCODE_WIDTH = 6;
    localparam logic [5:0]       DEFAULT_HALT_OPCODE  = 6'b111111;

    // Opcode sits in the MSBs of the instruction word; operands are widened
    // to 64 bits so one helper serves every INSTR_WIDTH/OPCODE_WIDTH pairing.
    function automatic logic [63:0] opcode_of(input logic [63:0] instr,
                                              input int          instr_w,
                                              input int          op_w);
        logic [63:0] mask;
        mask = (64'd1 << op_w) - 64'd1;
        return (instr >> (instr_w - op_w)) & mask;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of control, instruction-memory and IF/ID signals around the fetch stage.
// master is the fetch stage itself; slave is the surrounding pipeline/memory.
interface fetch_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
);
    logic                   notEnable;
    logic                   flush;
    logic                   branchTaken;
    logic [PC_WIDTH-1:0]    branchTarget;
    logic [PC_WIDTH-1:0]    imemAddr;
    logic [INSTR_WIDTH-1:0] imemData;
    logic [PC_WIDTH-1:0]    pcOut;
    logic [PC_WIDTH-1:0]    pcPlusOne;
    logic [INSTR_WIDTH-1:0] instrOut;
    logic                   validOut;
    logic                   halted;
    logic [CNT_WIDTH-1:0]   fetchCount;

    modport master (
        input  notEnable, flush, branchTaken, branchTarget, imemData,
        output imemAddr, pcOut, pcPlusOne, instrOut, validOut, halted, fetchCount
    );

    modport slave (
        output notEnable, flush, branchTaken, branchTarget, imemData,
        input  imemAddr, pcOut, pcPlusOne, instrOut, validOut, halted, fetchCount
    );
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: load captures a fetched instruction as valid,
// bubble clears only the valid bit, otherwise every field holds.
module fetch_ifid_reg #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   bubble,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic [PC_WIDTH-1:0]    pc_plus_one_in,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [PC_WIDTH-1:0]    pc_plus_one_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   valid_out
);
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pc_plus_one_q, pc_plus_one_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;

    // Bubbles leave the payload fields untouched; decode ignores them when invalid.
    always_comb begin
        pc_d          = pc_q;
        pc_plus_one_d = pc_plus_one_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        if (bubble) begin
            valid_d = 1'b0;
        end else if (load) begin
            pc_d          = pc_in;
            pc_plus_one_d = pc_plus_one_in;
            instr_d       = instr_in;
            valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= '0;
            pc_plus_one_q <= '0;
            instr_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_plus_one_q <= pc_plus_one_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
        end
    end

    assign pc_out          = pc_q;
    assign pc_plus_one_out = pc_plus_one_q;
    assign instr_out       = instr_q;
    assign valid_out       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation with branch/stall/flush, HALT-detect
// FSM, saturating fetched-instruction counter and the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                      PC_WIDTH     = 8,
    parameter int                      INSTR_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC     = '0,
    parameter int                      OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = OPCODE_WIDTH'(DEFAULT_HALT_OPCODE),
    parameter int                      CNT_WIDTH    = 16
) (
    input  logic     clock,
    input  logic     reset,
    fetch_if.master  bus
);
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    fetch_state_e         state_q, state_d;

    logic [PC_WIDTH-1:0]     pc_plus;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    is_halt_instr;
    logic                    ifid_load;
    logic                    ifid_bubble;
    logic                    halted_o;

    assign pc_plus       = pc_q + PC_WIDTH'(1);
    assign opcode        = OPCODE_WIDTH'(opcode_of(64'(bus.imemData), INSTR_WIDTH, OPCODE_WIDTH));
    assign is_halt_instr = (opcode == HALT_OPCODE);

    // Priority chain: branch > stall > flush > halted > normal fetch.
    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (bus.branchTaken) begin
            pc_d        = bus.branchTarget;
            ifid_bubble = 1'b1;
        end else if (bus.notEnable) begin
            pc_d = pc_q;
        end else if (bus.flush) begin
            ifid_bubble = 1'b1;
            if (state_q == ST_RUN) begin
                pc_d = pc_plus;
            end
        end else if (state_q == ST_HALTED) begin
            ifid_bubble = 1'b1;
        end else begin
            ifid_load = 1'b1;
            count_d   = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
            // The HALT word itself is latched; PC parks on it.
            if (!is_halt_instr) begin
                pc_d = pc_plus;
            end
        end
    end

    // Next-state: a flushed or stalled HALT word must not stop fetch.
    always_comb begin
        state_d = state_q;
        if (bus.branchTaken) begin
            state_d = ST_RUN;
        end else if (!bus.notEnable && !bus.flush &&
                     state_q == ST_RUN && is_halt_instr) begin
            state_d = ST_HALTED;
        end
    end

    always_comb begin
        halted_o = (state_q == ST_HALTED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    fetch_ifid_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ifid (
        .clock           (clock),
        .reset           (reset),
        .load            (ifid_load),
        .bubble          (ifid_bubble),
        .pc_in           (pc_q),
        .pc_plus_one_in  (pc_plus),
        .instr_in        (bus.imemData),
        .pc_out          (bus.pcOut),
        .pc_plus_one_out (bus.pcPlusOne),
        .instr_out       (bus.instrOut),
        .valid_out       (bus.validOut)
    );

    assign bus.imemAddr   = pc_q;
    assign bus.halted     = halted_o;
    assign bus.fetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver pushes each expected IF/ID
// capture, a negedge monitor pops and compares whenever validOut is high.
module tb_fetch_stage;
    localparam int PCW = 8;
    localparam int IW  = 32;
    localparam int CW  = 4;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [PCW-1:0] pcp1;
        logic [IW-1:0]  instr;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    fetch_stage #(
        .PC_WIDTH     (PCW),
        .INSTR_WIDTH  (IW),
        .RESET_PC     (8'h00),
        .OPCODE_WIDTH (6),
        .HALT_OPCODE  (6'b111111),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [IW-1:0] mem [256];
    assign bus.imemData = mem[bus.imemAddr];

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    logic [PCW-1:0] pc_m;
    logic           halted_m;
    logic           valid_m;
    logic [CW-1:0]  cnt_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT shows a valid IF/ID entry, one expectation is consumed.
    always @(negedge clock) begin
        exp_t e;
        if (bus.validOut === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pcOut=%0h with no expected capture", bus.pcOut);
            end else begin
                e = exp_q.pop_front();
                check("pcOut", 32'(bus.pcOut), 32'(e.pc));
                check("pcPlusOne", 32'(bus.pcPlusOne), 32'(e.pcp1));
                check("instrOut", bus.instrOut, e.instr);
            end
        end
    end

    // One clock edge of stimulus; the reference model follows the stage's documented behaviour.
    task automatic step(input logic rst, input logic br, input logic ne,
                        input logic fl, input logic [PCW-1:0] tgt);
        logic [IW-1:0] data;
        exp_t e;
        reset            = rst;
        bus.branchTaken  = br;
        bus.notEnable    = ne;
        bus.flush        = fl;
        bus.branchTarget = tgt;
        data = mem[pc_m];
        if (rst) begin
            pc_m = 8'h00; halted_m = 1'b0; valid_m = 1'b0; cnt_m = '0;
        end else if (br) begin
            pc_m = tgt; halted_m = 1'b0; valid_m = 1'b0;
        end else if (ne) begin
            if (valid_m) exp_q.push_back(last_exp);
        end else if (fl) begin
            valid_m = 1'b0;
            if (!halted_m) pc_m = pc_m + 8'd1;
        end else if (halted_m) begin
            valid_m = 1'b0;
        end else begin
            e.pc = pc_m; e.pcp1 = pc_m + 8'd1; e.instr = data;
            exp_q.push_back(e);
            last_exp = e;
            valid_m  = 1'b1;
            if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
            if (data[31:26] == 6'b111111) halted_m = 1'b1;
            else                          pc_m = pc_m + 8'd1;
        end
        @(posedge clock);
        #1;
        check("imemAddr", 32'(bus.imemAddr), 32'(pc_m));
        check("validOut", 32'(bus.validOut), 32'(valid_m));
        check("halted", 32'(bus.halted), 32'(halted_m));
        check("fetchCount", 32'(bus.fetchCount), 32'(cnt_m));
        $display("step rst=%b br=%b ne=%b fl=%b imemAddr=%02h valid=%b pcOut=%02h halted=%b cnt=%0d",
                 rst, br, ne, fl, bus.imemAddr, bus.validOut, bus.pcOut, bus.halted, bus.fetchCount);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0400_0000 | (i << 8) | i;
        mem[8'h10] = 32'hFC00_0010;
        pc_m = '0; halted_m = 1'b0; valid_m = 1'b0; cnt_m = '0; last_exp = '0;
        reset = 1'b1;
        bus.branchTaken = 1'b0; bus.notEnable = 1'b0; bus.flush = 1'b0; bus.branchTarget = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_pcOut", 32'(bus.pcOut), 32'h0);
        check("reset_instrOut", bus.instrOut, 32'h0);
        check("reset_imemAddr", 32'(bus.imemAddr), 32'h0);

        run(3);
        check("count_after_3", 32'(bus.fetchCount), 32'd3);
        check("pcPlusOne_2", 32'(bus.pcPlusOne), 32'h3);
        run(2);

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("stall_imemAddr", 32'(bus.imemAddr), 32'h5);
        check("stall_count", 32'(bus.fetchCount), 32'd5);
        run(1);
        check("release_pcOut", 32'(bus.pcOut), 32'h5);
        run(1);

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("flush_imemAddr", 32'(bus.imemAddr), 32'h8);
        check("flush_count", 32'(bus.fetchCount), 32'd7);

        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h40);
        check("branch_imemAddr", 32'(bus.imemAddr), 32'h40);
        check("branch_valid", 32'(bus.validOut), 32'h0);
        run(1);
        check("branch_pcOut", 32'(bus.pcOut), 32'h40);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0E);
        run(3);
        check("halt_pcOut", 32'(bus.pcOut), 32'h10);
        check("halt_flag", 32'(bus.halted), 32'h1);
        run(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("halt_imemAddr", 32'(bus.imemAddr), 32'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
        check("unhalt_flag", 32'(bus.halted), 32'h0);
        run(6);
        check("count_saturated", 32'(bus.fetchCount), 32'hF);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        run(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_pcOut", 32'(bus.pcOut), 32'h0);
        check("rst_count", 32'(bus.fetchCount), 32'h0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE);
        run(2);
        check("wrap_imemAddr", 32'(bus.imemAddr), 32'h00);
        check("wrap_pcPlusOne", 32'(bus.pcPlusOne), 32'h00);
        run(1);

        @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Parametrised instruction-fetch stage for the pipelined datapath: PC generation, sequential increment, branch redirect, stall and flush, plus the IF/ID pipeline register.
- Holds the PC and drives the instruction-memory address; imemData returns combinationally in the same cycle.
- Captures the fetched instruction, its PC and PC+1 with a valid bit for decode.
- Adds a HALT-detect state machine and a saturating fetched-instruction counter.

Parameters:
PC_WIDTH, 8, width of PC, imemAddr, branchTarget, pcOut, pcPlusOne
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
OPCODE_WIDTH, 6, opcode field width taken from instruction MSBs
HALT_OPCODE, 6'b111111, opcode that stops fetch
CNT_WIDTH, 16, width of fetchCount

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
notEnable  input  1  stall: hold PC and IF/ID when 1
flush  input  1  squash IF/ID contents (bubble) this cycle
branchTaken  input  1  redirect PC to branchTarget
branchTarget  input  PC_WIDTH  redirect address
imemAddr  output  PC_WIDTH  instruction memory address (= current PC, combinational)
imemData  input  INSTR_WIDTH  instruction at imemAddr
pcOut  output  PC_WIDTH  IF/ID: PC of held instruction
pcPlusOne  output  PC_WIDTH  IF/ID: pcOut+1 mod 2^PC_WIDTH
instrOut  output  INSTR_WIDTH  IF/ID: instruction
validOut  output  1  IF/ID: instruction valid
halted  output  1  1 while FSM in HALTED
fetchCount  output  CNT_WIDTH  valid instructions latched into IF/ID, saturating

Behaviour:
- One clock; reset synchronous, active-high. All state updates on the rising clock edge only.
- Reset: pc=RESET_PC; pcOut=0; pcPlusOne=0; instrOut=0; validOut=0; FSM=RUN (halted=0); fetchCount=0. Reset mid-operation discards everything, including HALTED.
- FSM states:
  - RUN: fetching.
  - HALTED: PC frozen, bubbles only.
- Per-edge priority, highest first: reset > branchTaken > notEnable > flush > HALTED > normal.
- branchTaken=1:
  - pc <= branchTarget.
  - validOut <= 0; other IF/ID fields may update but are don't-care.
  - FSM <= RUN.
  - Overrides notEnable and flush in the same cycle.
- notEnable=1 (no branch): pc, IF/ID and FSM hold; fetchCount holds.
- flush=1 (no branch, no stall):
  - validOut <= 0.
  - pc advances as in normal operation (pc+1), unless FSM is HALTED.
  - FSM does not transition, even if imemData is HALT.
- HALTED (no branch, stall or flush): pc holds; validOut <= 0 every cycle; halted=1.
- Normal RUN:
  - IF/ID <= {pc, pc+1, imemData, valid=1}; fetchCount += 1, saturating at all-ones.
  - If imemData[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE: the HALT instruction itself is latched valid, pc holds, FSM <= HALTED.
  - Otherwise pc <= pc+1.
- Width rules: pc+1 wraps modulo 2^PC_WIDTH (all-ones -> 0, no flag); pcPlusOne wraps the same way.
- Latency: instruction at PC p appears on instrOut/validOut one edge after p is on imemAddr (no stall).
- halted is a registered FSM decode: it rises on the edge that latches the HALT and falls on the edge that applies a branch.

Decomposition:
- Package fetch_pkg:
  - FSM state encoding (RUN=0, HALTED=1).
  - Default HALT_OPCODE and OPCODE_WIDTH constants.
  - Helper function for opcode extraction.
- Sub-module fetch_ifid_reg: IF/ID register with load/hold/bubble controls and synchronous reset.
- PC logic, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, memory returns non-HALT words -> imemAddr 0,1,2,3; pcOut 0,1,2 with validOut=1; pcPlusOne=pcOut+1; fetchCount=3 after third capture.
- notEnable=1 for 3 cycles at pc=5 -> imemAddr stays 5, IF/ID and fetchCount frozen; on release, the instruction at 5 is latched next edge.
- branchTaken=1 with target 8'h40 and notEnable=1 in the same cycle -> next imemAddr=8'h40, validOut=0; following cycle pcOut=8'h40, validOut=1.
- flush=1 at pc=7 -> validOut=0 next edge, imemAddr=8; fetchCount unchanged.
- HALT word at pc=0x10 -> latched valid with pcOut=0x10, halted=1, imemAddr stays 0x10, validOut=0 thereafter.
  - Then branchTaken to 0x20 -> halted=0, fetch resumes at 0x20.
  - Separately: reset while halted -> all outputs return to reset values.
- pc=8'hFF normal fetch -> imemAddr=8'h00 next; pcPlusOne=8'h00. Also preload fetchCount to all-ones with CNT_WIDTH=4 -> stays 4'hF.
